// File: rtl/axis_bram_adapter_pkg.sv
// rtl/axis_bram_adapter_pkg.sv - shared state encodings, slot ordering and defaults for the AXIS-to-BRAM adapter
package axis_bram_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Word 0 of a line lands in the most significant slot of the BRAM word.
  localparam bit WORD0_AT_MSB = 1'b1;

  localparam int DEF_BRAM_WIDTH_IN_WORD = 36;
  localparam int DEF_WORD_WIDTH         = 16;
  localparam int SLOT_W                 = 6;

  function automatic int slot_pos(input int slot, input int n);
    return WORD0_AT_MSB ? (n - 1 - slot) : slot;
  endfunction

endpackage

// File: rtl/axis_bram_line_packer_if.sv
// rtl/axis_bram_line_packer_if.sv - AXI-Stream word channel feeding the line packer
interface axis_bram_line_packer_if #(
  parameter int WORD_WIDTH = 16
) ();

  logic [WORD_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_bram_line_slot_reg.sv
// rtl/axis_bram_line_slot_reg.sv - slot-indexed word insert register for one BRAM line, with clear
module axis_bram_line_slot_reg
  import axis_bram_adapter_pkg::*;
#(
  parameter int BRAM_WIDTH_IN_WORD = DEF_BRAM_WIDTH_IN_WORD,
  parameter int WORD_WIDTH         = DEF_WORD_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     clr_i,
  input  logic                                     wr_i,
  input  logic [SLOT_W-1:0]                        slot_i,
  input  logic [WORD_WIDTH-1:0]                    wdata_i,
  output logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] merged_o
);

  logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] line_q;

  // merged_o is the line as it looks with the word being written this cycle already in place.
  always_comb begin
    merged_o = line_q;
    for (int s = 0; s < BRAM_WIDTH_IN_WORD; s++) begin
      if (wr_i && (slot_i == SLOT_W'(s))) begin
        merged_o[slot_pos(s, BRAM_WIDTH_IN_WORD)*WORD_WIDTH +: WORD_WIDTH] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      line_q <= '0;
    end else if (wr_i) begin
      line_q <= merged_o;
    end
  end

endmodule

// File: rtl/axis_bram_line_packer.sv
// rtl/axis_bram_line_packer.sv - packs stream words into BRAM lines; AXIS_BRAM_PACKER_STATS_EN adds word_count
module axis_bram_line_packer
  import axis_bram_adapter_pkg::*;
#(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = DEF_BRAM_WIDTH_IN_WORD,
  parameter int WORD_WIDTH         = DEF_WORD_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     start,
  input  logic [BRAM_ADDR_LENGTH-1:0]              bram_start_index,
  input  logic [BRAM_ADDR_LENGTH-1:0]              bram_bound_index,
  axis_bram_line_packer_if.slave                   s_axis,
  output logic                                     bram_en,
  output logic                                     bram_wen,
  output logic [BRAM_ADDR_LENGTH-1:0]              bram_index,
  output logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] bram_din,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     overflow
`ifdef AXIS_BRAM_PACKER_STATS_EN
  ,
  output logic [BRAM_ADDR_LENGTH+5:0]              word_count
`endif
);

  localparam int LINE_W = BRAM_WIDTH_IN_WORD * WORD_WIDTH;
  localparam int L      = BRAM_ADDR_LENGTH;

  state_e            state_q;
  logic [L-1:0]      bound_q;
  logic [L-1:0]      bram_index_q;
  logic [SLOT_W-1:0] cnt_q;
  logic              bram_en_q;
  logic              done_q;
  logic              overflow_q;
  logic [LINE_W-1:0] bram_din_q;

  logic [LINE_W-1:0] merged;
  logic              hs;
  logic              line_end;
  logic              last_line;
  logic              line_clr;
  logic [L-1:0]      line_addr;

  assign s_axis.tready = (state_q == FILL);
  assign hs            = (state_q == FILL) && s_axis.tvalid;
  assign line_end      = hs && ((cnt_q == SLOT_W'(BRAM_WIDTH_IN_WORD - 1)) || s_axis.tlast);
  assign line_clr      = line_end || ((state_q == IDLE) && start);

  // A one-word tlast line can finish while the previous strobe is still out, before the
  // post-strobe increment has landed, so the current line address folds that increment in.
  assign line_addr = bram_en_q ? (bram_index_q + L'(1)) : bram_index_q;
  assign last_line = s_axis.tlast || (line_addr == bound_q);

  axis_bram_line_slot_reg #(
    .BRAM_WIDTH_IN_WORD(BRAM_WIDTH_IN_WORD),
    .WORD_WIDTH        (WORD_WIDTH)
  ) u_slot_reg (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (line_clr),
    .wr_i    (hs),
    .slot_i  (cnt_q),
    .wdata_i (s_axis.tdata),
    .merged_o(merged)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      bound_q      <= '0;
      bram_index_q <= bram_start_index;
      cnt_q        <= '0;
      bram_en_q    <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      bram_din_q   <= '0;
    end else begin
      bram_en_q <= 1'b0;
      done_q    <= 1'b0;
      if (bram_en_q) begin
        bram_index_q <= bram_index_q + L'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= FILL;
            bram_index_q <= bram_start_index;
            bound_q      <= bram_bound_index;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
          end
        end
        FILL: begin
          if (hs) begin
            if (line_end) begin
              cnt_q        <= '0;
              bram_din_q   <= merged;
              bram_en_q    <= 1'b1;
              bram_index_q <= line_addr;
              if (last_line) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                if (!s_axis.tlast) begin
                  overflow_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + SLOT_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_BRAM_PACKER_STATS_EN
  localparam int WC_W = BRAM_ADDR_LENGTH + 6;
  logic [WC_W-1:0] word_count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_count_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      word_count_q <= '0;
    end else if (hs) begin
      word_count_q <= word_count_q + WC_W'(1);
    end
  end

  assign word_count = word_count_q;
`endif

  assign bram_en    = bram_en_q;
  assign bram_wen   = bram_en_q;
  assign bram_index = bram_index_q;
  assign bram_din   = bram_din_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule
